pc_control: RTL and testbench
=============================

PC_CONTROL -- requirements
Module: pc_control

Interface
REQ-001 SHALL have parameter PC_INIT, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ihit  input  1  instruction fetch at pc completes this cycle.
REQ-005 SHALL have port stall  input  1  hazard unit holds IF/ID; PC must not advance.
REQ-006 SHALL have port halt  input  1  halt instruction decoded in ID.
REQ-007 SHALL have ports ex_branch_taken (input, 1) and ex_branch_target (input, 32): resolved taken branch in EX and its target.
REQ-008 SHALL have ports ex_jr (input, 1) and ex_jr_target (input, 32): jump-register in EX and its register value.
REQ-009 SHALL have ports id_jump (input, 1) and id_jump_target (input, 32): J/JAL decoded in ID and its target.
REQ-010 SHALL have port pc  output  32  current fetch address.
REQ-011 SHALL have port pc_plus4  output  32  pc + 4, modulo 2^32.
REQ-012 SHALL have port npc_sel  output  2  next-PC mux select: 0 pc+4, 1 jump-register, 2 branch, 3 jump.
REQ-013 SHALL have ports pc_en (output, 1), flush_if (output, 1), flush_id (output, 1), redirect_pending (output, 1) and halted (output, 1).

Function
REQ-014 SHALL implement states RUN, HOLD (redirect latched, awaiting ihit) and HALT.
REQ-015 Redirect source priority SHALL be ex_branch_taken > ex_jr > id_jump > sequential.
REQ-016 In RUN, npc_sel SHALL combinationally encode the highest-priority active source.
REQ-017 In RUN, an EX redirect (branch or jr) SHALL be accepted regardless of stall.
REQ-018 id_jump SHALL be accepted only when stall=0.
REQ-019 An accepted EX redirect SHALL assert flush_if and flush_id for that cycle; an accepted id_jump SHALL assert flush_if only.
REQ-020 On an accepted redirect with ihit=1, pc SHALL load the target at the next edge and the state SHALL stay RUN.
REQ-021 On an accepted redirect with ihit=0, the target and source encoding SHALL be latched and the state SHALL move to HOLD; flushes SHALL still assert that cycle.
REQ-022 In HOLD, redirect_pending SHALL be 1 and npc_sel SHALL show the latched encoding.
REQ-023 In HOLD, pc SHALL load the latched target on the first cycle with ihit=1, with pc_en=1 and state returning to RUN.
REQ-024 In HOLD, a new EX redirect SHALL overwrite the latched target and flush again; id_jump SHALL be ignored.
REQ-025 With no redirect, pc_en SHALL equal ihit & ~stall, and pc SHALL load pc_plus4 when pc_en=1.
REQ-026 halt with pc_en=1 and no EX redirect SHALL move the state to HALT; an EX redirect in the same cycle SHALL win and halt SHALL be ignored.
REQ-027 In HALT, pc SHALL freeze, halted=1, pc_en=0 and flushes=0, and all inputs SHALL be ignored until reset.
REQ-028 Latency from an accepted redirect (with ihit=1) to the new pc value SHALL be one cycle.

Reset
REQ-029 While nRST=0, asynchronously: pc=PC_INIT, state=RUN, latched target=0, npc_sel=0.
REQ-030 While nRST=0, pc_en, flush_if, flush_id, redirect_pending and halted SHALL all be 0.
REQ-031 Reset asserted mid-HOLD or in HALT SHALL discard the pending redirect, and fetch SHALL resume from PC_INIT.

Verification
REQ-032 Sequential: ihit=1, stall=0 for 3 cycles from reset -> pc = 0, 4, 8, C; npc_sel=0.
REQ-033 Stall: pc=0x10, stall=1 with id_jump=1 target 0x400 -> pc holds 0x10, no flush; stall drops -> pc=0x400, flush_if=1 for one cycle.
REQ-034 Priority: ex_branch_taken target 0x80, ex_jr target 0x90 and id_jump target 0xA0 in the same cycle -> npc_sel=2, flush_if=flush_id=1, next pc=0x80.
REQ-035 HOLD: ex_jr target 0x200 while ihit=0 for 3 cycles -> redirect_pending=1, pc unchanged; ihit=1 -> pc=0x200, state RUN.
REQ-036 Halt: halt=1 at pc=0x20 with pc_en=1 -> halted=1 and pc stays 0x24 indefinitely; halt together with ex_branch_taken target 0x40 -> no halt, pc=0x40.
REQ-037 Wrap: pc=0xFFFF_FFFC, ihit=1 -> pc_plus4=0, next pc=0; nRST pulsed low in HOLD -> pc=PC_INIT, redirect_pending=0.

Source files
------------

// File: rtl/pc_control.sv
// Program counter and redirect sequencer: pc+4, jr, branch and jump sources; 1-cycle redirect latency.
// A redirect that arrives before ihit is latched (HOLD) and applied on ihit; stall freezes only sequential/jump fetch.
module pc_control #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        halt,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  input  logic        ex_jr,
  input  logic [31:0] ex_jr_target,
  input  logic        id_jump,
  input  logic [31:0] id_jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [1:0]  npc_sel,
  output logic        pc_en,
  output logic        flush_if,
  output logic        flush_id,
  output logic        redirect_pending,
  output logic        halted
);

  typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, HALT = 2'd2} state_t;

  localparam logic [1:0] SEL_SEQ  = 2'd0;
  localparam logic [1:0] SEL_JR   = 2'd1;
  localparam logic [1:0] SEL_BR   = 2'd2;
  localparam logic [1:0] SEL_JUMP = 2'd3;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_tgt, w_tgt_nxt;
  logic [1:0]  r_sel, w_sel_nxt;

  logic        w_ex, w_jmp;
  logic [1:0]  w_src_sel;
  logic [31:0] w_src_tgt;
  logic [1:0]  w_sel;
  logic        w_pc_en, w_flush_if, w_flush_id;

  assign pc_plus4 = r_pc + 32'd4;
  assign w_ex     = ex_branch_taken | ex_jr;
  assign w_jmp    = id_jump & ~stall;

  always_comb begin
    w_src_sel = SEL_JUMP;
    w_src_tgt = id_jump_target;
    if (ex_branch_taken) begin
      w_src_sel = SEL_BR;
      w_src_tgt = ex_branch_target;
    end else if (ex_jr) begin
      w_src_sel = SEL_JR;
      w_src_tgt = ex_jr_target;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    w_sel_nxt   = r_sel;
    w_sel       = SEL_SEQ;
    w_pc_en     = 1'b0;
    w_flush_if  = 1'b0;
    w_flush_id  = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_ex || w_jmp) begin
          w_sel      = w_src_sel;
          w_flush_if = 1'b1;
          w_flush_id = w_ex;
          if (ihit) begin
            w_pc_en  = 1'b1;
            w_pc_nxt = w_src_tgt;
            // halt decoded alongside an ID jump still stops once the jump lands
            if (halt && !w_ex) w_state_nxt = HALT;
          end else begin
            w_tgt_nxt   = w_src_tgt;
            w_sel_nxt   = w_src_sel;
            w_state_nxt = HOLD;
          end
        end else begin
          w_pc_en = ihit & ~stall;
          if (w_pc_en) begin
            w_pc_nxt = pc_plus4;
            if (halt) w_state_nxt = HALT;
          end
        end
      end
      HOLD: begin
        w_sel = r_sel;
        if (w_ex) begin
          w_sel      = w_src_sel;
          w_flush_if = 1'b1;
          w_flush_id = 1'b1;
          w_tgt_nxt  = w_src_tgt;
          w_sel_nxt  = w_src_sel;
        end
        if (ihit) begin
          w_pc_en     = 1'b1;
          w_pc_nxt    = w_ex ? w_src_tgt : r_tgt;
          w_state_nxt = RUN;
        end
      end
      HALT: begin
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= RUN;
      r_pc    <= PC_INIT;
      r_tgt   <= 32'd0;
      r_sel   <= SEL_SEQ;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  // Combinational outputs are forced quiet while reset is held
  assign pc               = r_pc;
  assign npc_sel          = nRST ? w_sel : SEL_SEQ;
  assign pc_en            = nRST & w_pc_en;
  assign flush_if         = nRST & w_flush_if;
  assign flush_id         = nRST & w_flush_id;
  assign redirect_pending = nRST & (r_state == HOLD);
  assign halted           = nRST & (r_state == HALT);

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control: sequential fetch, stall, priority, HOLD, halt, wrap and reset.
module tb_pc_control;
  logic        CLK, nRST, ihit, stall, halt;
  logic        ex_branch_taken, ex_jr, id_jump;
  logic [31:0] ex_branch_target, ex_jr_target, id_jump_target;
  logic [31:0] pc, pc_plus4;
  logic [1:0]  npc_sel;
  logic        pc_en, flush_if, flush_id, redirect_pending, halted;

  int errors = 0;
  int checks = 0;

  pc_control dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .stall(stall), .halt(halt),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .ex_jr(ex_jr), .ex_jr_target(ex_jr_target),
    .id_jump(id_jump), .id_jump_target(id_jump_target),
    .pc(pc), .pc_plus4(pc_plus4), .npc_sel(npc_sel), .pc_en(pc_en),
    .flush_if(flush_if), .flush_id(flush_id),
    .redirect_pending(redirect_pending), .halted(halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_redirects();
    ex_branch_taken = 0; ex_jr = 0; id_jump = 0; halt = 0;
  endtask

  initial begin
    nRST = 0; ihit = 1; stall = 0; halt = 0;
    ex_branch_taken = 0; ex_jr = 0; id_jump = 0;
    ex_branch_target = 0; ex_jr_target = 0; id_jump_target = 0;
    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_npc_sel", {30'd0, npc_sel}, 32'd0);
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_flush", {30'd0, flush_if, flush_id}, 32'd0);
    chk("rst_pend_halt", {30'd0, redirect_pending, halted}, 32'd0);
    tick();
    nRST = 1;
    #1;
    chk("seq_pc_en", {31'd0, pc_en}, 32'd1);

    // Sequential fetch
    tick(); chk("seq_pc4", pc, 32'h4);
    tick(); chk("seq_pc8", pc, 32'h8);
    tick(); chk("seq_pcC", pc, 32'hC);
    chk("seq_npc_sel", {30'd0, npc_sel}, 32'd0);
    tick(); chk("seq_pc10", pc, 32'h10);

    // Stall blocks the ID jump
    stall = 1; id_jump = 1; id_jump_target = 32'h400;
    #1;
    chk("stall_flush_if", {31'd0, flush_if}, 32'd0);
    chk("stall_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); chk("stall_pc_hold", pc, 32'h10);
    stall = 0;
    #1;
    chk("jump_flush", {30'd0, flush_if, flush_id}, 32'b10);
    chk("jump_npc_sel", {30'd0, npc_sel}, 32'd3);
    tick(); chk("jump_pc", pc, 32'h400);
    id_jump = 0;
    #1;
    chk("jump_flush_drop", {31'd0, flush_if}, 32'd0);

    // Priority: branch beats jr beats jump
    ex_branch_taken = 1; ex_branch_target = 32'h80;
    ex_jr = 1; ex_jr_target = 32'h90;
    id_jump = 1; id_jump_target = 32'hA0;
    #1;
    chk("prio_npc_sel", {30'd0, npc_sel}, 32'd2);
    chk("prio_flush", {30'd0, flush_if, flush_id}, 32'b11);
    tick(); chk("prio_pc", pc, 32'h80);
    clear_redirects();

    // HOLD: jr latched while fetch is outstanding
    ihit = 0; ex_jr = 1; ex_jr_target = 32'h200;
    #1;
    chk("hold_entry_flush", {30'd0, flush_if, flush_id}, 32'b11);
    chk("hold_entry_sel", {30'd0, npc_sel}, 32'd1);
    tick(); ex_jr = 0; #1;
    chk("hold_pend", {31'd0, redirect_pending}, 32'd1);
    chk("hold_sel_latched", {30'd0, npc_sel}, 32'd1);
    chk("hold_pc_en", {31'd0, pc_en}, 32'd0);
    tick(); chk("hold_pc_c2", pc, 32'h80);
    tick(); chk("hold_pc_c3", pc, 32'h80);
    ihit = 1; #1;
    chk("hold_release_en", {31'd0, pc_en}, 32'd1);
    tick(); chk("hold_release_pc", pc, 32'h200);
    chk("hold_release_pend", {31'd0, redirect_pending}, 32'd0);

    // HOLD overwrite by a later branch; ID jump ignored
    ihit = 0; ex_jr = 1; ex_jr_target = 32'h300;
    tick(); ex_jr = 0;
    ex_branch_taken = 1; ex_branch_target = 32'h280; #1;
    chk("ovr_flush", {30'd0, flush_if, flush_id}, 32'b11);
    chk("ovr_sel", {30'd0, npc_sel}, 32'd2);
    tick(); ex_branch_taken = 0;
    id_jump = 1; id_jump_target = 32'h500; #1;
    chk("ovr_jump_ignored", {30'd0, flush_if, flush_id}, 32'b00);
    ihit = 1;
    tick(); chk("ovr_pc", pc, 32'h280);
    id_jump = 0;

    // Halt after advancing from 0x20
    ex_branch_taken = 1; ex_branch_target = 32'h20;
    tick(); clear_redirects();
    chk("halt_setup_pc", pc, 32'h20);
    halt = 1;
    tick(); halt = 0;
    chk("halt_pc", pc, 32'h24);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    ex_branch_taken = 1; ex_branch_target = 32'h40; #1;
    chk("halt_ignore_flush", {30'd0, flush_if, flush_id}, 32'b00);
    chk("halt_ignore_en", {31'd0, pc_en}, 32'd0);
    tick(); tick(); tick();
    chk("halt_frozen_pc", pc, 32'h24);
    clear_redirects();
    nRST = 0; #1;
    chk("halt_rst_pc", pc, 32'h0);
    chk("halt_rst_halted", {31'd0, halted}, 32'd0);
    nRST = 1;

    // Halt loses to a same-cycle branch
    halt = 1; ex_branch_taken = 1; ex_branch_target = 32'h40;
    tick(); clear_redirects();
    chk("halt_br_pc", pc, 32'h40);
    chk("halt_br_halted", {31'd0, halted}, 32'd0);
    tick(); chk("halt_br_seq", pc, 32'h44);

    // Wrap around 2^32
    ex_branch_taken = 1; ex_branch_target = 32'hFFFF_FFFC;
    tick(); clear_redirects();
    chk("wrap_plus4", pc_plus4, 32'h0);
    tick(); chk("wrap_pc", pc, 32'h0);

    // Reset mid-HOLD discards the latched redirect
    ihit = 0; ex_jr = 1; ex_jr_target = 32'h300;
    tick(); ex_jr = 0; #1;
    chk("rhold_pend", {31'd0, redirect_pending}, 32'd1);
    nRST = 0; #1;
    chk("rhold_pc", pc, 32'h0);
    chk("rhold_pend_clr", {31'd0, redirect_pending}, 32'd0);
    nRST = 1; ihit = 1;
    tick(); chk("rhold_resume", pc, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
